mlg_decode_ctrl: RTL
====================

MLG_DECODE_CTRL -- requirements
Module: mlg_decode_ctrl

Interface
REQ-001 Parameter N, default 15, codeword length in bits.
REQ-002 Parameter CW, default 4, width of the shift counter and error counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 flush  input  1  synchronous abort; returns the block to IDLE.
REQ-006 in_word  input  N  received codeword; bit N-1 is the first bit corrected.
REQ-007 in_valid  input  1  in_word is valid.
REQ-008 in_ready  output  1  block can accept a codeword.
REQ-009 ct_out  output  N  current rotating register; drives the external majority-logic corrector.
REQ-010 cc_in  input  1  corrected bit for position N-1 of ct_out, returned combinationally by the corrector.
REQ-011 shift_en  output  1  high while a correction shift takes place this cycle.
REQ-012 out_word  output  N  corrected codeword.
REQ-013 out_nerr  output  CW  number of bit positions the corrector flipped.
REQ-014 out_valid  output  1  out_word and out_nerr are valid.
REQ-015 out_ready  input  1  downstream accepts the output.

Function
REQ-016 The FSM SHALL have three states: IDLE, DECODE and DONE.
REQ-017 In IDLE: in_ready=1, shift_en=0, out_valid=0.
REQ-018 An edge in IDLE with in_valid=1 SHALL:
- load ct <= in_word;
- clear cnt and nerr to 0;
- go to DECODE.
REQ-019 In DECODE: in_ready=0, shift_en=1, out_valid=0.
REQ-020 Each DECODE edge SHALL perform the following:
- ct <= {ct[N-2:0], cc_in} (rotate left, corrected MSB re-enters at bit 0);
- cnt <= cnt+1;
- nerr <= nerr+1 when cc_in != ct[N-1].
REQ-021 The DECODE edge with cnt==N-1 SHALL perform the final shift, then go to DONE; exactly N shifts per word.
REQ-022 After N rotations, ct SHALL be in original bit alignment; out_word = ct.
REQ-023 In DONE: out_valid=1, in_ready=0, shift_en=0; ct, nerr and cnt held.
REQ-024 out_word and out_nerr SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 A DONE edge with out_ready=1 SHALL go to IDLE; the next word is accepted no earlier than the following edge.
REQ-026 Latency: out_valid SHALL rise exactly N cycles after the accepting edge (15 for default N); throughput is one word per N+2 cycles minimum.
REQ-027 nerr SHALL saturate at 2^CW-1 and never wrap.
REQ-028 flush=1 SHALL force IDLE on the next edge from any state, discarding the word; flush has priority over in_valid and out_ready on the same edge.
REQ-029 in_valid in DECODE or DONE SHALL be ignored; the caller holds it.
REQ-030 ct_out SHALL equal ct in every state.
REQ-031 out_word SHALL equal ct; it is qualified only by out_valid.
REQ-032 Combinational paths: only cc_in -> next-state of ct and nerr; there is no input-to-output combinational path.

Reset
REQ-033 rst=0 SHALL asynchronously force the following:
- state=IDLE;
- ct=0, cnt=0, nerr=0;
- in_ready=1, shift_en=0, out_valid=0, out_word=0, out_nerr=0.
REQ-034 Reset asserted mid-DECODE or in DONE SHALL abandon the word; after rst deasserts, the first accepted word decodes normally.
REQ-035 Reset deassertion SHALL take effect at the first rising edge of clk after rst goes high.

Verification
REQ-036 The bench SHALL pair the DUT with a majority-logic corrector model (H(15,7) orthogonal checks on bit 14).
REQ-037 Error-free word: in_word=15'h0000 -> out_word=15'h0000, out_nerr=0, out_valid exactly 15 cycles after acceptance.
REQ-038 Single error: in_word=15'h4000 -> out_word=15'h0000, out_nerr=1; repeat for error in each bit position 0..14.
REQ-039 Double error: in_word=15'h4001 -> out_word=15'h0000, out_nerr=2.
REQ-040 Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_word and out_nerr stable, in_ready=0; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-041 Flush: assert flush at DECODE cnt=7 -> IDLE next edge, no out_valid; the next word decodes correctly.
REQ-042 Async reset: pull rst low mid-DECODE between edges -> outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mlg_decode_ctrl.sv
// Majority-logic decode controller.
// Loads a received codeword into a rotating register and shifts it N times
// through an external majority-logic corrector. The corrected MSB comes back
// on cc_in and re-enters at bit 0. After N rotations the register is back in
// its original alignment and holds the corrected word. The number of
// positions the corrector flipped is counted, saturating at 2^CW-1.
// All outputs are decoded from registers, so the only combinational input
// dependency is cc_in feeding the next-state of ct and nerr.
module mlg_decode_ctrl #(
   parameter int N  = 15,
   parameter int CW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   input  logic [N-1:0]  in_word,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  ct_out,
   input  logic          cc_in,
   output logic          shift_en,
   output logic [N-1:0]  out_word,
   output logic [CW-1:0] out_nerr,
   output logic          out_valid,
   input  logic          out_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
   localparam logic [CW-1:0] NERR_MAX = {CW{1'b1}};

   state_t        state_q, state_d;
   logic [N-1:0]  ct_q, ct_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] nerr_q, nerr_d;

   // State, rotating register, shift counter and error counter
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         ct_q    <= '0;
         cnt_q   <= '0;
         nerr_q  <= '0;
      end else begin
         state_q <= state_d;
         ct_q    <= ct_d;
         cnt_q   <= cnt_d;
         nerr_q  <= nerr_d;
      end
   end

   // Next-state logic; a flush abandons the word without doing a shift
   always_comb begin
      state_d = state_q;
      ct_d    = ct_q;
      cnt_d   = cnt_q;
      nerr_d  = nerr_q;

      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  ct_d    = in_word;
                  cnt_d   = '0;
                  nerr_d  = '0;
                  state_d = DECODE;
               end
            end
            DECODE: begin
               ct_d  = {ct_q[N-2:0], cc_in};
               cnt_d = cnt_q + CW'(1);
               if ((cc_in != ct_q[N-1]) && (nerr_q != NERR_MAX)) begin
                  nerr_d = nerr_q + CW'(1);
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state_d = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // Handshake and shift strobes decoded purely from the state register
   always_comb begin
      in_ready  = (state_q == IDLE);
      shift_en  = (state_q == DECODE);
      out_valid = (state_q == DONE);
   end

   // Data outputs are the registers themselves, qualified by out_valid
   always_comb begin
      ct_out   = ct_q;
      out_word = ct_q;
      out_nerr = nerr_q;
   end

endmodule
